alsu_result_fifo: RTL
=====================

# alsu_result_fifo

Registered output stage directly downstream of the 4-bit AND/OR/XOR/XNOR logic unit. It captures each result together with its 2-bit select code and derived status flags (zero, odd parity) into a small FIFO. The results are then presented to the ALSU output consumer over a valid/ready handshake. This decouples the combinational logic unit from a consumer that may stall.

## Interface
Parameters:
- WIDTH, 4, result width in bits; matches the logic-unit `Out` width.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries; has priority over push and pop.
- in_valid  input  1  upstream result is valid this cycle.
- in_ready  output  1  FIFO can accept an entry; equals !full.
- in_result  input  WIDTH  result from the logic unit (`Out`).
- in_sel  input  2  select code that produced the result (00 AND, 01 OR, 10 XOR, 11 XNOR).
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer accepts the head entry.
- out_result  output  WIDTH  head result.
- out_sel  output  2  head select code.
- out_zero  output  1  head result == 0.
- out_parity  output  1  XOR-reduction of the head result (1 = odd number of ones).
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- push = in_valid && in_ready.
- pop = out_valid && out_ready.
- Flags are computed at push time from in_result and stored with the entry. They are not recomputed at the output.
- Storage:
  - DEPTH-entry array of {sel, result, zero, parity}.
  - Write pointer and read pointer, each $clog2(DEPTH) bits; both wrap modulo DEPTH.
  - Occupancy counter.
- Each cycle, in priority order:
  - flush: both pointers and count go to 0; push and pop are ignored.
  - push and pop together: write at wptr, advance both pointers, count unchanged. Legal only when 0 < count < DEPTH: push needs !full and pop needs !empty.
  - push only: write at wptr, wptr+1, count+1.
  - pop only: rptr+1, count-1.
- full = (count == DEPTH). empty = (count == 0). out_valid = !empty.
- in_valid while full: in_ready is low, so nothing is written and no state changes. The upstream must hold its data.
- Outputs out_result/out_sel/out_zero/out_parity:
  - Always drive the entry at rptr.
  - When empty the values are don't-care, but they must not be X after reset; the storage array is reset to 0.
- There is no combinational input-to-output bypass. An entry pushed into an empty FIFO appears on the output on the following cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, out_result=0, out_sel=00, out_zero=0, out_parity=0; all storage = 0.
- Reset asserted mid-operation: all entries are discarded immediately (asynchronously). The first push after deassertion behaves as into an empty FIFO.
- Latency from push to out_valid: 1 cycle.
- in_ready depends only on registered count, so there is no combinational path from out_ready to in_ready.
- out_valid and the output data are registered-state-derived, so there is no path from in_* to out_*.
- Throughput: one entry per cycle sustained whenever 0 < count < DEPTH and both sides are active.
- Full with out_ready=1: the pop occurs, and in_ready rises on the next cycle (one-bubble recovery).
- Pointer wrap: after DEPTH pushes, wptr returns to 0. Ordering is strictly FIFO across the wrap.

## Structure
- Shared package alsu_pkg holds:
  - select-code constants SEL_AND=2'b00, SEL_OR=2'b01, SEL_XOR=2'b10, SEL_XNOR=2'b11;
  - the FIFO entry record type (sel, result, zero, parity).
- One sub-module, alsu_flag_gen: combinational; takes a WIDTH-bit result and produces zero and parity. It is reusable by later arithmetic stages.
- Pointer/count logic stays in alsu_result_fifo.

## Test plan
- Reset then idle:
  - Stimulus: assert rst, release it, hold in_valid=0 for 5 cycles.
  - Required: in_ready=1, out_valid=0, count=0 and all outputs 0 throughout.
- Single push and pop:
  - Stimulus: push result 4'b0000, sel 00; hold out_ready=0.
  - Required: next cycle out_valid=1, out_result=0000, out_zero=1, out_parity=0, count=1.
  - Then assert out_ready for 1 cycle; required: count=0.
- Fill to full:
  - Stimulus: push 1001/01, 0110/10, 1011/10, 0011/11 with out_ready=0.
  - Required: count=4, in_ready=0.
  - A fifth push of 1111 is not accepted.
  - Draining returns the four entries in order with parity 0,0,1,0.
- Simultaneous push and pop:
  - Stimulus: hold count=2 and push and pop every cycle for 8 cycles, covering both pointer wraps.
  - Required: count stays 2 and output order matches input order.
- Flush priority:
  - Stimulus: with count=3, assert flush together with in_valid=1 and out_ready=1.
  - Required: next cycle count=0, out_valid=0; the concurrent push is discarded.
- Async reset mid-stream:
  - Stimulus: with count=2, pulse rst between clock edges.
  - Required: out_valid=0 and count=0 immediately, before the next edge.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU datapath: select codes and the result FIFO entry record.
package alsu_pkg;

   localparam logic [1:0] SEL_AND  = 2'b00;
   localparam logic [1:0] SEL_OR   = 2'b01;
   localparam logic [1:0] SEL_XOR  = 2'b10;
   localparam logic [1:0] SEL_XNOR = 2'b11;

   localparam int ALSU_RES_W = 4;

   // Flags travel with the entry so the output side never recomputes them.
   typedef struct packed {
      logic [1:0]            sel;
      logic [ALSU_RES_W-1:0] result;
      logic                  zero;
      logic                  parity;
   } alsu_entry_t;

endpackage

// File: rtl/alsu_flag_gen.sv
// Status flags for a result word: zero detect and odd parity.
module alsu_flag_gen #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity
);

   assign zero   = ~|result;
   assign parity = ^result;

endmodule

// File: rtl/alsu_result_fifo.sv
// Registered result FIFO between the logic unit and the ALSU output consumer.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
module alsu_result_fifo
   import alsu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_result,
   input  logic [1:0]                 in_sel,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_result,
   output logic [1:0]                 out_sel,
   output logic                       out_zero,
   output logic                       out_parity,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   alsu_entry_t    mem_q [DEPTH];
   alsu_entry_t    mem_d [DEPTH];
   logic [PW-1:0]  wptr_q, wptr_d;
   logic [PW-1:0]  rptr_q, rptr_d;
   logic [CW-1:0]  count_q, count_d;

   logic           full, empty, push, pop;
   logic           new_zero, new_parity;
   alsu_entry_t    new_entry;
   alsu_entry_t    head;

   alsu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .result (in_result),
      .zero   (new_zero),
      .parity (new_parity)
   );

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      new_entry        = '0;
      new_entry.sel    = in_sel;
      new_entry.result = in_result;
      new_entry.zero   = new_zero;
      new_entry.parity = new_parity;
   end

   // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap for free.
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[wptr_q] = new_entry;
            wptr_d        = wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_d = rptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   assign head       = mem_q[rptr_q];
   assign out_result = head.result;
   assign out_sel    = head.sel;
   assign out_zero   = head.zero;
   assign out_parity = head.parity;
   assign count      = count_q;

endmodule
